uart_receiver: RTL and testbench

- UART receive path: deserialises 8-bit frames (1 start, 8 data LSB-first, 1 parity, 1 stop) from the serial line RxD into a parallel byte with valid and error strobes.
- Timing comes from the 16x oversampling tick `sample_ENABLE`, driven by the existing baud tick generator. The receiver has no internal baud divider.
- Sits between the pad-side RxD line and the byte-consuming logic. It is the receive counterpart of the transmit path that shares the same baud tick.

---
 rtl/uart_receiver.sv | 199 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver
// Receive half of the UART. Deserialises 11-bit frames into a parallel byte:
// 1 start bit, 8 data bits LSB-first, 1 parity bit, 1 stop bit.
// Bit timing comes from an external oversampling tick. The receiver has no
// baud divider of its own.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   sample_ENABLE oversampling tick, one clk wide, OVERSAMPLE ticks per bit
//   Rx_EN         receiver enable; low aborts to IDLE and clears the strobes
//   RxD           asynchronous serial line, idle high
//   Rx_DATA       last correctly received byte
//   Rx_VALID      one-clk strobe: Rx_DATA was just loaded with a good frame
//   Rx_PERROR     parity error of the last frame (held until the next start)
//   Rx_FERROR     framing error of the last frame (stop bit sampled low)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line idle, waiting for a tick that sees rxd_s low
// START  | counting to mid start bit, re-checking it to reject glitches
// DATA   | sampling 8 data bits at mid-bit, shifting LSB-first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit; returns to IDLE on that same tick

module uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_ENABLE,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state, state_nxt;
  logic          rxd_m, rxd_s;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift_q, shift_nxt;
  logic          par_q, par_nxt;
  logic          stop_q, stop_nxt;
  logic          done_q, done_nxt;
  logic          start_det;
  logic          par_err;

  // Two-flop synchroniser. It resets to the idle level so that leaving
  // reset cannot look like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= RxD;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shift_q  <= shift_nxt;
      par_q    <= par_nxt;
      stop_q   <= stop_nxt;
      done_q   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_q;
    par_nxt   = par_q;
    stop_nxt  = stop_q;
    done_nxt  = 1'b0;
    start_det = 1'b0;

    // The enable is checked before the tick, so a tick that lands on the
    // same edge as an abort is dropped.
    if (!Rx_EN) begin
      state_nxt = IDLE;
      tick_nxt  = '0;
      bit_nxt   = '0;
      shift_nxt = '0;
    end else if (sample_ENABLE) begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state_nxt = START;
            tick_nxt  = '0;
            start_det = 1'b1;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            tick_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = rxd_s ? IDLE : DATA;
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            shift_nxt = {rxd_s, shift_q[7:1]};
            bit_nxt   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_nxt = PARITY;
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end
        PARITY: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            par_nxt   = rxd_s;
            state_nxt = STOP;
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end
        STOP: begin
          // Going back to IDLE at mid stop bit lets a following start bit
          // be detected without waiting out the rest of the stop bit.
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            stop_nxt  = rxd_s;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign par_err = (^shift_q) ^ par_q ^ PARITY_ODD;

  // The frame result is registered one clk after the stop-bit tick. If the
  // frame result and a start detection fall on the same edge, the result
  // wins, so the flags always reflect a frame that has finished.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Rx_DATA   <= 8'h00;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else if (!Rx_EN) begin
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_VALID <= 1'b0;
      if (done_q) begin
        Rx_PERROR <= par_err;
        Rx_FERROR <= ~stop_q;
        if (!par_err && stop_q) begin
          Rx_DATA  <= shift_q;
          Rx_VALID <= 1'b1;
        end
      end else if (start_det) begin
        Rx_PERROR <= 1'b0;
        Rx_FERROR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver. It runs a table of known frames, then
// random frames checked against a parity/stop model, then hand-written
// sequences for glitches, enable abort and reset in the middle of a frame.
module tb_uart_receiver;

  localparam int  OS          = 16;
  localparam bit  PODD        = 1'b0;
  localparam int  CLK_PER_BIT = OS * 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_ENABLE;
  logic       Rx_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  uart_receiver #(.OVERSAMPLE(OS), .PARITY_ODD(PODD)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_ENABLE(sample_ENABLE),
    .Rx_EN        (Rx_EN),
    .RxD          (RxD),
    .Rx_DATA      (Rx_DATA),
    .Rx_VALID     (Rx_VALID),
    .Rx_PERROR    (Rx_PERROR),
    .Rx_FERROR    (Rx_FERROR)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int phase      = 0;
  logic [7:0] exp_data = 8'h00;

  // Monitor: counts valid strobes and rising edges of the error flags.
  int         valid_cnt = 0;
  int         pe_rise   = 0;
  int         fe_rise   = 0;
  logic [7:0] last_vdata = 8'h00;
  logic       pe_prev = 1'b0;
  logic       fe_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (Rx_VALID === 1'b1) begin
        valid_cnt++;
        last_vdata = Rx_DATA;
      end
      if (Rx_PERROR === 1'b1 && !pe_prev) pe_rise++;
      if (Rx_FERROR === 1'b1 && !fe_prev) fe_rise++;
      pe_prev = (Rx_PERROR === 1'b1);
      fe_prev = (Rx_FERROR === 1'b1);
    end
  end

  typedef struct {
    logic [7:0] d;
    bit         p;
    bit         s;
    bit         v;
    bit         pe;
    bit         fe;
    int         gap;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Tick every 4th clk; all stimulus changes on the falling edge.
  task automatic step();
    @(negedge clk);
    phase = (phase == 3) ? 0 : phase + 1;
    sample_ENABLE = (phase == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_bit(input bit b);
    RxD = b;
    repeat (CLK_PER_BIT) step();
  endtask

  // Reference model: a good frame has the right count of ones over
  // data+parity and a high stop bit.
  function automatic void model(input logic [7:0] d, input bit p, input bit s,
                                output bit v, output bit pe, output bit fe);
    int ones;
    ones = $countones(d) + int'(p);
    pe = ((ones % 2) == 1) != PODD;
    fe = !s;
    v  = !pe && !fe;
  endfunction

  task automatic apply_frame(input string tag, input logic [7:0] d, input bit p, input bit s,
                             input bit ev, input bit epe, input bit efe, input int gap);
    int v0, pe0, fe0;
    v0 = valid_cnt;
    send_bit(1'b0);
    pe0 = pe_rise;
    fe0 = fe_rise;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    if (s) begin
      check({tag, " perror_level"}, 32'(Rx_PERROR), 32'(epe));
      check({tag, " ferror_level"}, 32'(Rx_FERROR), 32'(efe));
    end else begin
      RxD = 1'b1;
      idle(2 * CLK_PER_BIT);
    end
    idle(gap);
    if (ev) exp_data = d;
    check({tag, " valid_pulses"}, 32'(valid_cnt - v0), 32'(ev));
    check({tag, " perror_set"}, 32'(pe_rise - pe0), 32'(epe));
    check({tag, " ferror_set"}, 32'(fe_rise - fe0), 32'(efe));
    check({tag, " rx_data"}, 32'(Rx_DATA), 32'(exp_data));
    if (ev) check({tag, " strobe_data"}, 32'(last_vdata), 32'(d));
  endtask

  initial begin
    // data, parity, stop, valid, perror, ferror, idle gap (clk)
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 40};
    tbl[1] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[2] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30};
    tbl[3] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 30};
    tbl[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20};
    tbl[5] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10};
    tbl[6] = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10};
    tbl[7] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[8] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 50};

    reset = 1'b0;
    Rx_EN = 1'b1;
    RxD   = 1'b1;
    sample_ENABLE = 1'b0;
    idle(4);
    check("reset rx_data", 32'(Rx_DATA), 32'h00);
    check("reset rx_valid", 32'(Rx_VALID), 32'h0);
    check("reset rx_perror", 32'(Rx_PERROR), 32'h0);
    check("reset rx_ferror", 32'(Rx_FERROR), 32'h0);
    reset = 1'b1;
    idle(20);

    for (int i = 0; i < 9; i++)
      apply_frame($sformatf("tbl%0d", i), tbl[i].d, tbl[i].p, tbl[i].s,
                  tbl[i].v, tbl[i].pe, tbl[i].fe, tbl[i].gap);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      bit p, s, v, pe, fe;
      d = 8'($urandom);
      p = 1'($urandom % 2);
      s = (($urandom % 4) != 0);
      model(d, p, s, v, pe, fe);
      apply_frame($sformatf("rnd%0d", i), d, p, s, v, pe, fe, int'($urandom_range(0, 90)));
    end

    // Glitch: 3 ticks low, then high. Nothing may change.
    begin
      int v0;
      logic [7:0] d0;
      v0 = valid_cnt;
      d0 = Rx_DATA;
      RxD = 1'b0;
      idle(12);
      RxD = 1'b1;
      idle(2 * CLK_PER_BIT);
      check("glitch valid", 32'(valid_cnt - v0), 32'h0);
      check("glitch rx_data", 32'(Rx_DATA), 32'(d0));
      check("glitch flags", 32'({Rx_PERROR, Rx_FERROR}), 32'h0);
    end
    apply_frame("after_glitch", 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30);

    // Parity error flag clears when the next start bit is detected.
    apply_frame("perr", 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 20);
    send_bit(1'b0);
    check("perror cleared by start", 32'(Rx_PERROR), 32'h0);
    for (int i = 0; i < 8; i++) send_bit(1'(8'hC3 >> i));
    send_bit(1'b0);
    send_bit(1'b1);
    exp_data = 8'hC3;
    check("post perr rx_data", 32'(Rx_DATA), 32'hC3);
    idle(20);

    // Rx_EN low clears held error flags.
    apply_frame("perr2", 8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10);
    Rx_EN = 1'b0;
    idle(3);
    check("en_low clears perror", 32'(Rx_PERROR), 32'h0);
    Rx_EN = 1'b1;
    idle(10);

    // Rx_EN abort in the middle of the data bits of 0x77.
    begin
      int v0;
      v0 = valid_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'(8'h77 >> i));
      Rx_EN = 1'b0;
      idle(2);
      RxD = 1'b1;
      idle(8 * CLK_PER_BIT);
      Rx_EN = 1'b1;
      idle(2 * CLK_PER_BIT);
      check("abort valid", 32'(valid_cnt - v0), 32'h0);
      check("abort rx_data", 32'(Rx_DATA), 32'(exp_data));
    end
    apply_frame("after_abort", 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20);

    // Asynchronous reset in the middle of a 0x33 frame.
    begin
      int v0;
      v0 = valid_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'(8'h33 >> i));
      #2 reset = 1'b0;
      #1;
      check("midreset rx_data", 32'(Rx_DATA), 32'h00);
      check("midreset valid", 32'(Rx_VALID), 32'h0);
      check("midreset flags", 32'({Rx_PERROR, Rx_FERROR}), 32'h0);
      exp_data = 8'h00;
      RxD = 1'b1;
      idle(10);
      reset = 1'b1;
      idle(6 * CLK_PER_BIT);
      check("midreset no strobe", 32'(valid_cnt - v0), 32'h0);
      check("midreset data held", 32'(Rx_DATA), 32'h00);
    end
    apply_frame("after_reset", 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
